spi_slave_regfile: RTL and testbench

SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

---
 rtl/spi_slave_regfile.sv | 170 +++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave fronting a 16x8 register file: first byte of a frame is a command
// (bit7 read, bits3:0 start address), following bytes stream data with an auto-incrementing pointer.
module spi_slave_regfile #(
    parameter logic [7:0] STATUS_BYTE = 8'h5A
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       spi_sclk,
    input  logic       spi_ss_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [3:0] local_addr,
    output logic [7:0] local_rdata,
    output logic       wr_pulse,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_abort,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StCmd, StWrData, StRdData} state_e;

    // Bit 0: first sync flop, bit 1: synchronized value, bit 2: previous value for edge detect.
    logic [2:0] sclk_sync_q;
    logic [2:0] ss_sync_q;
    logic [1:0] mosi_sync_q;

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        byte_done_q, byte_done_d;
    logic        wr_pulse_q, wr_pulse_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        frame_abort_q, frame_abort_d;
    logic [1:0]  init_q, init_d;
    logic        armed_q, armed_d;
    logic [7:0]  regs_q [16];

    logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic [7:0] rx_byte;
    logic       reg_we;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
    assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
    assign rx_byte   = {rx_shift_q[6:0], mosi_sync_q[1]};

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        ptr_d         = ptr_q;
        byte_done_d   = byte_done_q;
        wr_pulse_d    = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_abort_d = 1'b0;
        reg_we        = 1'b0;
        init_d        = (init_q == 2'd3) ? init_q : init_q + 2'd1;
        // Only accept a frame once a genuine SS_n-high level has been seen after reset.
        armed_d       = armed_q | ((init_q == 2'd3) & ss_sync_q[1]);

        if (state_q == StIdle) begin
            if (ss_fall && armed_q) begin
                state_d     = StCmd;
                tx_shift_d  = STATUS_BYTE;
                bit_cnt_d   = 3'd0;
                byte_done_d = 1'b0;
            end
        end else begin
            if (sclk_rise) begin
                rx_shift_d = rx_byte;
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_done_d = 1'b1;
                    case (state_q)
                        StCmd: begin
                            state_d = rx_byte[7] ? StRdData : StWrData;
                            ptr_d   = rx_byte[3:0];
                        end
                        StWrData: begin
                            reg_we     = 1'b1;
                            wr_pulse_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = rx_byte;
                            ptr_d      = ptr_q + 4'd1;
                        end
                        default: ;
                    endcase
                end
            end
            if (sclk_fall) begin
                if (byte_done_q) begin
                    byte_done_d = 1'b0;
                    if (state_q == StRdData) begin
                        tx_shift_d = regs_q[ptr_q];
                        ptr_d      = ptr_q + 4'd1;
                    end else begin
                        tx_shift_d = 8'h00;
                    end
                end else begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
            // A byte completing on the same cycle as deselect still counts as whole.
            if (ss_rise) begin
                state_d = StIdle;
                if (bit_cnt_d != 3'd0) begin
                    frame_abort_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sclk_sync_q   <= 3'b000;
            ss_sync_q     <= 3'b111;
            mosi_sync_q   <= 2'b00;
            state_q       <= StIdle;
            bit_cnt_q     <= 3'd0;
            rx_shift_q    <= 8'h00;
            tx_shift_q    <= 8'h00;
            ptr_q         <= 4'd0;
            byte_done_q   <= 1'b0;
            wr_pulse_q    <= 1'b0;
            wr_addr_q     <= 4'd0;
            wr_data_q     <= 8'h00;
            frame_abort_q <= 1'b0;
            init_q        <= 2'd0;
            armed_q       <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            sclk_sync_q   <= {sclk_sync_q[1:0], spi_sclk};
            ss_sync_q     <= {ss_sync_q[1:0], spi_ss_n};
            mosi_sync_q   <= {mosi_sync_q[0], spi_mosi};
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            ptr_q         <= ptr_d;
            byte_done_q   <= byte_done_d;
            wr_pulse_q    <= wr_pulse_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_abort_q <= frame_abort_d;
            init_q        <= init_d;
            armed_q       <= armed_d;
            if (reg_we) begin
                regs_q[ptr_q] <= rx_byte;
            end
        end
    end

    assign busy        = (state_q != StIdle);
    assign spi_miso    = busy ? tx_shift_q[7] : 1'b0;
    assign local_rdata = regs_q[local_addr];
    assign wr_pulse    = wr_pulse_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: write/read frames, pointer wrap, aborted byte, mid-frame reset.
module tb_spi_slave_regfile;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic       spi_sclk;
    logic       spi_ss_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [3:0] local_addr;
    logic [7:0] local_rdata;
    logic       wr_pulse;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_abort;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    int         wr_cnt = 0;
    int         ab_cnt = 0;
    logic [3:0] wa_log [8];
    logic [7:0] wd_log [8];

    spi_slave_regfile #(.STATUS_BYTE(8'h5A)) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .spi_sclk     (spi_sclk),
        .spi_ss_n     (spi_ss_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .local_addr   (local_addr),
        .local_rdata  (local_rdata),
        .wr_pulse     (wr_pulse),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_abort  (frame_abort),
        .busy         (busy)
    );

    always #5 clk_clk = ~clk_clk;

    // Every high cycle of a strobe is logged, so a stretched pulse shows up as an extra count.
    always @(negedge clk_clk) begin
        if (wr_pulse) begin
            wa_log[wr_cnt[2:0]] = wr_addr;
            wd_log[wr_cnt[2:0]] = wr_data;
            wr_cnt = wr_cnt + 1;
        end
        if (frame_abort) ab_cnt = ab_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic ss_begin();
        spi_ss_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic ss_end();
        wait_clk(8);
        spi_ss_n = 1'b1;
        wait_clk(10);
    endtask

    // Shift the top n bits of tx MSB first; MISO is sampled just before each SCLK rise.
    task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = tx[i];
            wait_clk(8);
            rx[i] = spi_miso;
            spi_sclk = 1'b1;
            wait_clk(8);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        local_addr = a;
        #1;
        check_eq(tag, local_rdata, exp);
    endtask

    logic [7:0] m0, m1, m2;
    int         wr_base, ab_base;
    logic [7:0] acc;

    initial begin
        reset_reset_n = 1'b0;
        spi_sclk      = 1'b0;
        spi_ss_n      = 1'b1;
        spi_mosi      = 1'b0;
        local_addr    = 4'd0;
        wait_clk(3);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_miso", spi_miso, 1'b0);
        check_eq("rst_wr_pulse", wr_pulse, 1'b0);
        check_eq("rst_wr_addr", wr_addr, 4'd0);
        check_eq("rst_wr_data", wr_data, 8'h00);
        check_eq("rst_abort", frame_abort, 1'b0);
        acc = 8'h00;
        for (int a = 0; a < 16; a++) begin
            local_addr = a[3:0];
            #1;
            acc = acc | local_rdata;
        end
        check_eq("rst_regs_zero", acc, 8'h00);
        reset_reset_n = 1'b1;
        wait_clk(8);

        // Write 11, 22 starting at reg3.
        wr_base = wr_cnt;
        ss_begin();
        xfer_bits(8'h03, 8, m0);
        xfer_bits(8'h11, 8, m1);
        xfer_bits(8'h22, 8, m2);
        ss_end();
        check_eq("wr_miso0", m0, 8'h5A);
        check_eq("wr_miso1", m1, 8'h00);
        check_eq("wr_miso2", m2, 8'h00);
        check_eq("wr_pulse_cnt", wr_cnt - wr_base, 2);
        check_eq("wr0_addr", wa_log[wr_base % 8], 4'd3);
        check_eq("wr0_data", wd_log[wr_base % 8], 8'h11);
        check_eq("wr1_addr", wa_log[(wr_base + 1) % 8], 4'd4);
        check_eq("wr1_data", wd_log[(wr_base + 1) % 8], 8'h22);
        check_reg("reg3_after_wr", 4'd3, 8'h11);
        check_reg("reg4_after_wr", 4'd4, 8'h22);
        check_eq("busy_after_wr", busy, 1'b0);

        // Read back from reg3 with two dummy bytes that must not write.
        wr_base = wr_cnt;
        ss_begin();
        xfer_bits(8'h83, 8, m0);
        xfer_bits(8'hFF, 8, m1);
        xfer_bits(8'hEE, 8, m2);
        ss_end();
        check_eq("rd_miso0", m0, 8'h5A);
        check_eq("rd_miso1", m1, 8'h11);
        check_eq("rd_miso2", m2, 8'h22);
        check_eq("rd_no_wr", wr_cnt - wr_base, 0);
        check_reg("reg3_after_rd", 4'd3, 8'h11);
        check_reg("reg4_after_rd", 4'd4, 8'h22);
        check_reg("reg5_after_rd", 4'd5, 8'h00);

        // Pointer wrap 15 -> 0 on write and read.
        ss_begin();
        xfer_bits(8'h0F, 8, m0);
        xfer_bits(8'hAA, 8, m1);
        xfer_bits(8'hBB, 8, m2);
        ss_end();
        check_reg("reg15_wrap", 4'd15, 8'hAA);
        check_reg("reg0_wrap", 4'd0, 8'hBB);
        ss_begin();
        xfer_bits(8'h8F, 8, m0);
        xfer_bits(8'h00, 8, m1);
        xfer_bits(8'h00, 8, m2);
        ss_end();
        check_eq("wrap_rd_miso0", m0, 8'h5A);
        check_eq("wrap_rd_miso1", m1, 8'hAA);
        check_eq("wrap_rd_miso2", m2, 8'hBB);

        // Deselect after 5 data bits: discard, abort strobe.
        wr_base = wr_cnt;
        ab_base = ab_cnt;
        ss_begin();
        xfer_bits(8'h05, 8, m0);
        xfer_bits(8'hC3, 5, m1);
        ss_end();
        check_reg("reg5_abort", 4'd5, 8'h00);
        check_eq("abort_no_wr", wr_cnt - wr_base, 0);
        check_eq("abort_cnt", ab_cnt - ab_base, 1);
        check_eq("abort_busy", busy, 1'b0);
        ss_begin();
        xfer_bits(8'h05, 8, m0);
        xfer_bits(8'h77, 8, m1);
        ss_end();
        check_reg("reg5_after_abort", 4'd5, 8'h77);
        check_eq("after_abort_wr", wr_cnt - wr_base, 1);
        check_eq("clean_end_no_abort", ab_cnt - ab_base, 1);

        // Reset pulse in the middle of a read frame.
        ab_base = ab_cnt;
        ss_begin();
        xfer_bits(8'h83, 8, m0);
        xfer_bits(8'h00, 3, m1);
        check_eq("mid_frame_busy", busy, 1'b1);
        reset_reset_n = 1'b0;
        wait_clk(1);
        reset_reset_n = 1'b1;
        check_eq("midrst_miso", spi_miso, 1'b0);
        check_eq("midrst_busy", busy, 1'b0);
        acc = 8'h00;
        for (int a = 0; a < 16; a++) begin
            local_addr = a[3:0];
            #1;
            acc = acc | local_rdata;
        end
        check_eq("midrst_regs_zero", acc, 8'h00);
        wait_clk(12);
        check_eq("midrst_wait_fresh_fall", busy, 1'b0);
        spi_ss_n = 1'b1;
        wait_clk(10);
        check_eq("midrst_no_abort", ab_cnt - ab_base, 0);
        ss_begin();
        xfer_bits(8'h01, 8, m0);
        xfer_bits(8'h55, 8, m1);
        ss_end();
        check_eq("post_rst_status", m0, 8'h5A);
        check_reg("post_rst_reg1", 4'd1, 8'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
